// File: rtl/aes_key_schedule_seq.sv
// aes_key_schedule_seq
// Iterative AES key expander: one 32-bit schedule word per clock. It uses four
// forward S-box lanes in place of one S-box per word.
// Optional feature macro: KEY_SCHED_STREAM_EN adds a registered per-round-key
// stream (rk_valid / rk_idx / rk_out) alongside the flat expanded_keys bus.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// S_IDLE   | waiting for start; the accept edge is the load (no dwell cycle)
// S_EXPAND | one schedule word w[i] written per edge, i = Nk .. 4*(Nr+1)-1
// S_DONE   | one-cycle done pulse, expanded_keys complete and held
module aes_key_schedule_seq #(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [Nk*32-1:0]        key_in,
  output logic                    busy,
  output logic                    done,
  output logic [(Nr+1)*128-1:0]   expanded_keys
`ifdef KEY_SCHED_STREAM_EN
  ,
  output logic                    rk_valid,
  output logic [3:0]              rk_idx,
  output logic [127:0]            rk_out
`endif
);

  localparam int NW = 4 * (Nr + 1);
  localparam int IW = $clog2(NW + 1);

  // Forward S-box, byte x at bits [2047-8x -: 8].
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[11'd2047 - {x, 3'b000} -: 8];
  endfunction

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPAND,
    S_DONE
  } state_t;

  state_t         state, state_nxt;
  logic [31:0]    w     [NW];
  logic [31:0]    w_nxt [NW];
  logic [IW-1:0]  idx;
  logic [2:0]     kmod;
  logic [7:0]     rcon;

  logic           accept;
  logic           last_write;
  logic [31:0]    w_prev;
  logic [31:0]    w_back;
  logic [31:0]    sub_in;
  logic [31:0]    sub_out;
  logic [31:0]    temp;
  logic [31:0]    new_word;

  assign accept     = (state == S_IDLE) && start;
  assign last_write = (state == S_EXPAND) && (idx == IW'(NW - 1));

  assign w_prev   = w[idx - IW'(1)];
  assign w_back   = w[idx - IW'(Nk)];
  assign sub_in   = (kmod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
  assign new_word = w_back ^ temp;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    assign sub_out[8*b +: 8] = sbox(sub_in[8*b +: 8]);
  end

  // temp term of the recurrence, selected by position within the key period
  always_comb begin
    temp = w_prev;
    if (kmod == 3'd0) begin
      temp = sub_out ^ {rcon, 24'h000000};
    end else if ((Nk == 8) && (kmod == 3'd4)) begin
      temp = sub_out;
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic; start is only looked at in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_EXPAND;
      S_EXPAND: if (last_write) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state == S_EXPAND);
  assign done = (state == S_DONE);

  // next contents of the word array: key load on accept, one word per EXPAND edge
  always_comb begin
    for (int k = 0; k < NW; k++) begin
      w_nxt[k] = w[k];
    end
    if (accept) begin
      for (int k = 0; k < Nk; k++) begin
        w_nxt[k] = key_in[(Nk-1-k)*32 +: 32];
      end
    end else if (state == S_EXPAND) begin
      w_nxt[idx] = new_word;
    end
  end

  // word array, index, key-period counter and round constant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NW; k++) begin
        w[k] <= 32'h0;
      end
      idx  <= '0;
      kmod <= 3'd0;
      rcon <= 8'h01;
    end else begin
      for (int k = 0; k < NW; k++) begin
        w[k] <= w_nxt[k];
      end
      if (accept) begin
        idx  <= IW'(Nk);
        kmod <= 3'd0;
        rcon <= 8'h01;
      end else if (state == S_EXPAND) begin
        idx  <= idx + IW'(1);
        kmod <= (kmod == 3'(Nk - 1)) ? 3'd0 : kmod + 3'd1;
        if (kmod == 3'd0) begin
          rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        end
      end
    end
  end

  // flat view of the schedule, w[0] in the MSBs
  always_comb begin
    expanded_keys = '0;
    for (int k = 0; k < NW; k++) begin
      expanded_keys[(NW-1-k)*32 +: 32] = w[k];
    end
  end

`ifdef KEY_SCHED_STREAM_EN
  // Words complete after the current edge decide which round key can go out.
  // The load can complete up to two round keys at once; the extra one drains
  // on the next edge, before expansion completes the following round.
  logic [3:0]     r_emit;
  logic [3:0]     r_cur;
  logic [6:0]     words_nxt;
  logic [6:0]     words_need;
  logic [IW-1:0]  rk_base;
  logic           emit;

  assign r_cur      = accept ? 4'd0 : r_emit;
  assign words_nxt  = accept ? 7'(Nk)
                    : (state == S_EXPAND) ? 7'(idx) + 7'd1
                    : 7'(idx);
  assign words_need = 7'({r_cur, 2'b00}) + 7'd4;
  assign emit       = (accept || (state == S_EXPAND)) && (words_need <= words_nxt);
  assign rk_base    = IW'({r_cur, 2'b00});

  // registered round-key stream, one key per pulse in ascending order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_emit   <= 4'd0;
      rk_valid <= 1'b0;
      rk_idx   <= 4'd0;
      rk_out   <= 128'h0;
    end else begin
      rk_valid <= emit;
      if (emit) begin
        r_emit <= r_cur + 4'd1;
        rk_idx <= r_cur;
        rk_out <= {w_nxt[rk_base], w_nxt[rk_base + IW'(1)],
                   w_nxt[rk_base + IW'(2)], w_nxt[rk_base + IW'(3)]};
      end
    end
  end
`endif

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Directed bench for aes_key_schedule_seq: one instance each for Nk = 4, 6, 8,
// checked against FIPS-197 schedule values.
module tb_aes_key_schedule_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start_a, start_b, start_c;
  logic [127:0] key_a;
  logic [191:0] key_b;
  logic [255:0] key_c;
  logic         busy_a, busy_b, busy_c;
  logic         done_a, done_b, done_c;
  logic [1407:0] ek_a;
  logic [1663:0] ek_b;
  logic [1919:0] ek_c;
`ifdef KEY_SCHED_STREAM_EN
  logic         rkv_a, rkv_b, rkv_c;
  logic [3:0]   rki_a, rki_b, rki_c;
  logic [127:0] rko_a, rko_b, rko_c;
`endif

  aes_key_schedule_seq #(.Nk(4)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .key_in(key_a),
    .busy(busy_a), .done(done_a), .expanded_keys(ek_a)
`ifdef KEY_SCHED_STREAM_EN
    , .rk_valid(rkv_a), .rk_idx(rki_a), .rk_out(rko_a)
`endif
  );

  aes_key_schedule_seq #(.Nk(6)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .key_in(key_b),
    .busy(busy_b), .done(done_b), .expanded_keys(ek_b)
`ifdef KEY_SCHED_STREAM_EN
    , .rk_valid(rkv_b), .rk_idx(rki_b), .rk_out(rko_b)
`endif
  );

  aes_key_schedule_seq #(.Nk(8)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .key_in(key_c),
    .busy(busy_c), .done(done_c), .expanded_keys(ek_c)
`ifdef KEY_SCHED_STREAM_EN
    , .rk_valid(rkv_c), .rk_idx(rki_c), .rk_out(rko_c)
`endif
  );

  localparam logic [255:0] K1 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] K2 = 256'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K3 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K4 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  typedef struct {
    int           sel;
    logic [255:0] key;
    int           rnd;
    logic [127:0] exp;
  } vec_t;

  vec_t tv [13];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_done(input int sel);
    case (sel)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic logic [127:0] get_round(input int sel, input int r);
    case (sel)
      0:       return ek_a[1407 - 128*r -: 128];
      1:       return ek_b[1663 - 128*r -: 128];
      default: return ek_c[1919 - 128*r -: 128];
    endcase
  endfunction

  function automatic int n_exp(input int sel);
    case (sel)
      0:       return 40;
      1:       return 46;
      default: return 52;
    endcase
  endfunction

  task automatic drive(input int sel, input logic s, input logic [255:0] key);
    case (sel)
      0:       begin start_a = s; key_a = key[127:0]; end
      1:       begin start_b = s; key_b = key[191:0]; end
      default: begin start_c = s; key_c = key;        end
    endcase
  endtask

  // accept on the next edge, then count edges until done is seen (-1 on timeout)
  task automatic run(input int sel, input logic [255:0] key, output int lat);
    drive(sel, 1'b1, key);
    tick();
    drive(sel, 1'b0, key);
    check($sformatf("busy_after_accept_%0d", sel), 256'(get_busy(sel)), 256'(1));
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (get_done(sel)) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int           lat;
    int           last_sel;
    logic [255:0] last_key;
    int           d1, d2, cnt;

    tv[0]  = '{0, K1, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    tv[1]  = '{0, K1, 1,  128'ha0fafe1788542cb123a339392a6c7605};
    tv[2]  = '{0, K1, 2,  128'hf2c295f27a96b9435935807a7359f67f};
    tv[3]  = '{0, K1, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    tv[4]  = '{0, K2, 1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe};
    tv[5]  = '{0, K2, 10, 128'h13111d7fe3944a17f307a78b4d2b30c5};
    tv[6]  = '{1, K3, 0,  128'h8e73b0f7da0e6452c810f32b809079e5};
    tv[7]  = '{1, K3, 1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5};
    tv[8]  = '{1, K3, 12, 128'he98ba06f448c773c8ecc720401002202};
    tv[9]  = '{2, K4, 0,  128'h603deb1015ca71be2b73aef0857d7781};
    tv[10] = '{2, K4, 1,  128'h1f352c073b6108d72d9810a30914dff4};
    tv[11] = '{2, K4, 2,  128'h9ba354118e6925afa51a8b5f2067fcde};
    tv[12] = '{2, K4, 14, 128'hfe4890d1e6188d0b046df344706c631e};

    rst_n = 1'b0;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    drive(2, 1'b0, '0);
    repeat (3) tick();
    check("reset_busy",   256'({busy_a, busy_b, busy_c}), 256'(0));
    check("reset_done",   256'({done_a, done_b, done_c}), 256'(0));
    check("reset_keys",   256'((ek_a == '0) && (ek_b == '0) && (ek_c == '0)), 256'(1));
    rst_n = 1'b1;
    tick();

    // table-driven: one expansion per distinct (instance, key), then round checks
    last_sel = -1;
    last_key = '0;
    for (int i = 0; i < 13; i++) begin
      if ((tv[i].sel != last_sel) || (tv[i].key !== last_key)) begin
        run(tv[i].sel, tv[i].key, lat);
        check($sformatf("latency_v%0d", i), 256'(lat), 256'(n_exp(tv[i].sel)));
        tick();
        check($sformatf("done_width_v%0d", i), 256'({get_done(tv[i].sel), get_busy(tv[i].sel)}), 256'(0));
        last_sel = tv[i].sel;
        last_key = tv[i].key;
      end
      check($sformatf("round%0d_v%0d", tv[i].rnd, i), 256'(get_round(tv[i].sel, tv[i].rnd)), 256'(tv[i].exp));
    end

    // second start with a different key during EXPAND must be ignored
    drive(0, 1'b1, K1);
    tick();
    drive(0, 1'b0, K1);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (n == 4) drive(0, 1'b1, K2);
      if (n == 5) drive(0, 1'b0, K2);
      if (done_a) begin
        lat = n;
        break;
      end
    end
    check("ignore_latency", 256'(lat), 256'(40));
    check("ignore_round10", 256'(get_round(0, 10)), 256'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
    check("ignore_round0",  256'(get_round(0, 0)),  256'(K1[127:0]));
    tick();

    // reset in the middle of an expansion
    drive(0, 1'b1, K1);
    tick();
    drive(0, 1'b0, K1);
    repeat (20) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_keys", 256'(ek_a == '0), 256'(1));
    check("midrst_flags", 256'({busy_a, done_a}), 256'(0));
    tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (done_a || busy_a) cnt++;
    end
    check("midrst_no_done", 256'(cnt), 256'(0));
    run(0, K2, lat);
    check("midrst_rerun_latency", 256'(lat), 256'(40));
    check("midrst_rerun_round10", 256'(get_round(0, 10)), 256'(128'h13111d7fe3944a17f307a78b4d2b30c5));
    tick();

    // start held high: re-accept on the first IDLE edge after done
    drive(0, 1'b1, K1);
    d1 = -1;
    d2 = -1;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (done_a) begin
        if (d1 < 0) d1 = n;
        else begin
          d2 = n;
          break;
        end
      end
    end
    drive(0, 1'b0, K1);
    check("b2b_first_done", 256'(d1), 256'(41));
    check("b2b_spacing", 256'(d2 - d1), 256'(42));
    check("b2b_round10", 256'(get_round(0, 10)), 256'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
    repeat (3) tick();
    check("b2b_idle", 256'({busy_a, done_a}), 256'(0));

`ifdef KEY_SCHED_STREAM_EN
    // round-key stream on the Nk=8 instance: 15 pulses, ascending, last with done
    drive(2, 1'b1, K4);
    tick();
    drive(2, 1'b0, K4);
    cnt = 0;
    for (int n = 0; n <= 80; n++) begin
      if (rkv_c) begin
        check($sformatf("stream_idx_%0d", cnt), 256'(rki_c), 256'(cnt));
        if (cnt == 0)
          check("stream_round0", 256'(rko_c), 256'(128'h603deb1015ca71be2b73aef0857d7781));
        if (cnt == 1)
          check("stream_round1", 256'(rko_c), 256'(128'h1f352c073b6108d72d9810a30914dff4));
        if (cnt == 14) begin
          check("stream_round14", 256'(rko_c), 256'(128'hfe4890d1e6188d0b046df344706c631e));
          check("stream_last_with_done", 256'(done_c), 256'(1));
        end
        cnt++;
      end
      if (done_c) break;
      tick();
    end
    check("stream_count", 256'(cnt), 256'(15));
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
